// File: rtl/lsu_mmio.sv
// lsu_mmio: data-side load-store unit for the RV32I core.
//   Maps into the low 4 KB of address space:
//     0x000-0x7FF              word-addressed data memory (wraps modulo DMEM_WORDS)
//     IO_BASE + 16*k (k<NUM_OUT)  32-bit output register k
//     SW_ADDR                  read-only switch register (2-flop synchronised io_sw_i)
//   Byte/half/word accesses. Loads are right-justified and extended; stores
//   write only the enabled byte lanes. Responses are registered and pulse for
//   one cycle.
//
// Optional feature macro: LSU_MISALIGN_EN
//   defined   - misaligned data-memory accesses are split into two beats
//               (word index, then index+1 with wrap at the top of memory)
//   undefined - misaligned data-memory accesses return an error
//
// Ports:
//   clk_i, rst_ni          clock (rising edge), async active-low reset
//   req_valid_i/ready_o    request handshake; ready only in IDLE
//   req_addr_i             byte address, [11:0] decoded
//   req_we_i               1 = store, 0 = load
//   req_size_i             00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_i         zero-extend loads
//   req_wdata_i            store data, right-justified
//   rsp_valid_o            one-cycle response pulse
//   rsp_rdata_o            load result (0 for stores and errors)
//   rsp_err_o              access error, valid with rsp_valid_o
//   io_sw_i                asynchronous switch inputs
//   io_out_o               output registers, register k at [32k+31:32k]
//
// state | meaning
// IDLE  | ready; beat 1 (or the only beat) is performed on acceptance
// SPLIT | second beat of a misaligned memory access at word index+1
// RESP  | registered response presented for one cycle

module lsu_mmio #(
    parameter int unsigned DMEM_WORDS = 512,
    parameter int unsigned NUM_OUT    = 11,
    parameter logic [11:0] IO_BASE    = 12'h800,
    parameter logic [11:0] SW_ADDR    = 12'h900
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [31:0]            req_addr_i,
    input  logic                   req_we_i,
    input  logic [1:0]             req_size_i,
    input  logic                   req_unsigned_i,
    input  logic [31:0]            req_wdata_i,
    output logic                   rsp_valid_o,
    output logic [31:0]            rsp_rdata_o,
    output logic                   rsp_err_o,
    input  logic [31:0]            io_sw_i,
    output logic [32*NUM_OUT-1:0]  io_out_o
);

    localparam int unsigned AW = $clog2(DMEM_WORDS);

`ifdef LSU_MISALIGN_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SPLIT = 2'd1, S_RESP = 2'd2} state_e;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RESP = 2'd2} state_e;
`endif

    state_e state_q, state_d;

    logic [31:0] mem [DMEM_WORDS];
    logic [31:0] out_q [NUM_OUT];
    logic [31:0] sw_s1, sw_s2;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    function automatic logic [31:0] load_ext(input logic [31:0] raw,
                                             input logic [1:0]  size,
                                             input logic        uns);
        case (size)
            2'b00:   return uns ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'b01:   return uns ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    // ---------------- request decode ----------------
    logic [11:0]   a;
    logic [1:0]    off;
    logic [11:0]   io_off;
    logic [3:0]    io_k;
    logic [AW-1:0] idx;
    logic [2:0]    nbytes;
    logic [3:0]    size_mask;
    logic          size_bad, misal;
    logic          in_mem, in_io, in_sw;
    logic          req_err, need_split, accept;
    logic [3:0]    be_lo;
    logic [31:0]   wd_lo;
    logic [31:0]   rd_word;
    logic          io_wr;
    logic          unused_bits;

    assign a      = req_addr_i[11:0];
    assign off    = a[1:0];
    assign idx    = a[AW+1:2];
    assign io_off = a - IO_BASE;
    assign io_k   = io_off[7:4];

    always_comb begin
        nbytes    = 3'd0;
        size_mask = 4'b0000;
        size_bad  = 1'b0;
        case (req_size_i)
            2'b00:   begin nbytes = 3'd1; size_mask = 4'b0001; end
            2'b01:   begin nbytes = 3'd2; size_mask = 4'b0011; end
            2'b10:   begin nbytes = 3'd4; size_mask = 4'b1111; end
            default: size_bad = 1'b1;
        endcase
    end

    assign misal  = (({1'b0, off} + nbytes) > 3'd4);
    assign in_mem = ~a[11];
    assign in_io  = ~in_mem && (a >= IO_BASE) && (io_off[11:4] < 8'(NUM_OUT))
                    && (io_off[3:2] == 2'b00);
    assign in_sw  = ~in_mem && ~in_io && (a[11:2] == SW_ADDR[11:2]);

    always_comb begin
        req_err = size_bad | ~(in_mem | in_io | in_sw) | (in_sw & req_we_i)
                | ((in_io | in_sw) & misal);
`ifndef LSU_MISALIGN_EN
        req_err = req_err | (in_mem & misal);
`endif
    end

    assign accept = req_valid_i & req_ready_o;
    assign io_wr  = accept & req_we_i & in_io & ~req_err;

    // Lane steering: store byte i lands on lane (off + i). With splitting the
    // 8-lane view spans word idx (lanes 0-3) and word idx+1 (lanes 4-7).
`ifdef LSU_MISALIGN_EN
    logic [7:0]  be_dw;
    logic [63:0] wd_dw;
    assign be_dw      = {4'b0000, size_mask} << off;
    assign wd_dw      = {32'h0, req_wdata_i} << {off, 3'b000};
    assign be_lo      = be_dw[3:0];
    assign wd_lo      = wd_dw[31:0];
    assign need_split = in_mem & misal & ~size_bad;
`else
    assign be_lo      = size_mask << off;
    assign wd_lo      = req_wdata_i << {off, 3'b000};
    assign need_split = 1'b0;
`endif

    assign unused_bits = ^{req_addr_i[31:12], io_off[1:0], a};

    always_comb begin
        rd_word = '0;
        if (in_mem) begin
            rd_word = mem[idx];
        end else if (in_sw) begin
            rd_word = sw_s2;
        end else if (in_io) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (io_k == 4'(k)) rd_word = out_q[k];
            end
        end
    end

    // ---------------- second-beat context ----------------
`ifdef LSU_MISALIGN_EN
    logic [AW-1:0] sp_idx;
    logic [3:0]    sp_be;
    logic [31:0]   sp_wd;
    logic [31:0]   sp_lo;
    logic [1:0]    sp_off;
    logic [1:0]    sp_size;
    logic          sp_uns;
    logic          sp_we;
    logic [31:0]   sp_raw;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sp_idx  <= '0;
            sp_be   <= '0;
            sp_wd   <= '0;
            sp_lo   <= '0;
            sp_off  <= '0;
            sp_size <= '0;
            sp_uns  <= 1'b0;
            sp_we   <= 1'b0;
        end else if (accept && need_split) begin
            sp_idx  <= idx + AW'(1);
            sp_be   <= be_dw[7:4];
            sp_wd   <= wd_dw[63:32];
            sp_lo   <= rd_word;
            sp_off  <= off;
            sp_size <= req_size_i;
            sp_uns  <= req_unsigned_i;
            sp_we   <= req_we_i;
        end
    end

    assign sp_raw = 32'({mem[sp_idx], sp_lo} >> {sp_off, 3'b000});
`endif

    // ---------------- data memory (not reset) ----------------
    logic          mem_we;
    logic [AW-1:0] mem_widx;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wd;

    always_comb begin
        mem_we   = 1'b0;
        mem_widx = idx;
        mem_be   = be_lo;
        mem_wd   = wd_lo;
        if (state_q == S_IDLE) begin
            mem_we = accept & req_we_i & in_mem & ~req_err;
        end
`ifdef LSU_MISALIGN_EN
        else if (state_q == S_SPLIT) begin
            mem_we   = sp_we;
            mem_widx = sp_idx;
            mem_be   = sp_be;
            mem_wd   = sp_wd;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) mem[mem_widx][8*i +: 8] <= mem_wd[8*i +: 8];
            end
        end
    end

    // ---------------- output registers and switch synchroniser ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_OUT; k++) out_q[k] <= '0;
        end else if (io_wr) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (io_k == 4'(k)) begin
                    for (int i = 0; i < 4; i++) begin
                        if (be_lo[i]) out_q[k][8*i +: 8] <= wd_lo[8*i +: 8];
                    end
                end
            end
        end
    end

    genvar gk;
    generate
        for (gk = 0; gk < NUM_OUT; gk++) begin : g_out
            assign io_out_o[32*gk +: 32] = out_q[gk];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= io_sw_i;
            sw_s2 <= sw_s1;
        end
    end

    // ---------------- response registers ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else if (accept && !need_split) begin
            rsp_err_q   <= req_err;
            rsp_rdata_q <= (req_err || req_we_i) ? '0
                         : load_ext(rd_word >> {off, 3'b000}, req_size_i, req_unsigned_i);
        end
`ifdef LSU_MISALIGN_EN
        else if (state_q == S_SPLIT) begin
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= sp_we ? '0 : load_ext(sp_raw, sp_size, sp_uns);
        end
`endif
    end

    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
`ifdef LSU_MISALIGN_EN
                    state_d = need_split ? S_SPLIT : S_RESP;
`else
                    state_d = S_RESP;
`endif
                end
            end
`ifdef LSU_MISALIGN_EN
            S_SPLIT: state_d = S_RESP;
`endif
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (state_q == S_IDLE);
        rsp_valid_o = (state_q == S_RESP);
    end

endmodule
